// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and encodings for the pipeline hazard controller
// Contents: FSM state enum, forward-select codes, resultSrc codes and the
// register-match helper used by the forwarding and load-use logic.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Execute-stage operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // resultSrc encodings carried down the pipe
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  // True when a stage writing rd produces the value a consumer reads from rs.
  // x0 is hardwired to zero, so it never matches.
  function automatic logic rd_hit(input logic wr, input logic [4:0] rd,
                                  input logic [4:0] rs);
    return wr && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - datapath <-> hazard controller signal bundle
// master: datapath side (drives Decode fields, branch and dmem status).
// slave : hazard controller (drives forward selects, stalls, flushes, status).
//   rs1_D/rs2_D/rd_D, regWrite_D, resultSrc_D : Decode-stage instruction fields
//   pcSrc_E                                    : branch/jump taken in Execute
//   dmemReq_M/dmemReady_M                      : Memory-stage access / completion
//   forwardA_E/forwardB_E                      : Execute operand selects
//   stall_F..stall_W, flush_D/flush_E          : pipeline register controls
//   memTimeout, stallCycles, flushCount        : error flag and perf counters
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       rs1_D;
  logic [4:0]       rs2_D;
  logic [4:0]       rd_D;
  logic             regWrite_D;
  logic [1:0]       resultSrc_D;
  logic             pcSrc_E;
  logic             dmemReq_M;
  logic             dmemReady_M;
  logic [1:0]       forwardA_E;
  logic [1:0]       forwardB_E;
  logic             stall_F;
  logic             stall_D;
  logic             stall_E;
  logic             stall_M;
  logic             stall_W;
  logic             flush_D;
  logic             flush_E;
  logic             memTimeout;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output rs1_D, rs2_D, rd_D, regWrite_D, resultSrc_D,
    output pcSrc_E, dmemReq_M, dmemReady_M,
    input  forwardA_E, forwardB_E,
    input  stall_F, stall_D, stall_E, stall_M, stall_W,
    input  flush_D, flush_E, memTimeout, stallCycles, flushCount
  );

  modport slave (
    input  rs1_D, rs2_D, rd_D, regWrite_D, resultSrc_D,
    input  pcSrc_E, dmemReq_M, dmemReady_M,
    output forwardA_E, forwardB_E,
    output stall_F, stall_D, stall_E, stall_M, stall_W,
    output flush_D, flush_E, memTimeout, stallCycles, flushCount
  );

endinterface

// File: rtl/hazard_ctrl_fwd_select.sv
// rtl/hazard_ctrl_fwd_select.sv - forwarding source select for one Execute operand
// Ports:
//   rs                 in  5  source register of the instruction in Execute
//   rd_M, regWrite_M   in     destination/write flag of the instruction in Memory
//   rd_W, regWrite_W   in     destination/write flag of the instruction in Writeback
//   sel                out 2  FWD_MEM, FWD_WB or FWD_RF
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_M,
  input  logic       regWrite_M,
  input  logic [4:0] rd_W,
  input  logic       regWrite_W,
  output logic [1:0] sel
);

  // Memory holds the younger producer, so it wins over Writeback.
  always_comb begin
    sel = FWD_RF;
    if (rd_hit(regWrite_M, rd_M, rs)) begin
      sel = FWD_MEM;
    end else if (rd_hit(regWrite_W, rd_W, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I five-stage pipeline hazard controller
// Ports:
//   clk    in  core clock
//   reset  in  synchronous active-high reset
//   hz     slave side of hazard_ctrl_if (Decode fields and Execute/Memory status
//          in; forward selects, stalls, flushes, memTimeout and counters out)
// Parameters:
//   MEM_TIMEOUT  consecutive MEM_WAIT cycles before memTimeout sets
//   CNT_W        performance counter width
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  // Shadow pipeline: only the fields the hazard rules need at each stage
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic       reg_write_e;
  logic [1:0] result_src_e;
  logic [4:0] rd_m, rd_w;
  logic       reg_write_m, reg_write_w;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_inc;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  logic freeze, late_stall;
  logic stall_fd, stall_emw, flush_d, flush_e, br_flush;

  // Freeze follows the live miss, so it already holds the pipe in the first
  // miss cycle before the FSM has moved to MEM_WAIT.
  assign freeze = hz.dmemReq_M && !hz.dmemReady_M;

  // Results that are not ALU results (load data, PC+4) are not on aluResult_M
  // a cycle later, so a dependent instruction in Decode must wait one cycle.
  assign late_stall = reg_write_e && (result_src_e != RES_ALU) && (rd_e != 5'd0) &&
                      ((rd_e == hz.rs1_D) || (rd_e == hz.rs2_D));

  // Priority: reset, then memory freeze, then taken branch, then late stall.
  always_comb begin
    stall_fd  = 1'b0;
    stall_emw = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    br_flush  = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (freeze) begin
      stall_fd  = 1'b1;
      stall_emw = 1'b1;
    end else if (hz.pcSrc_E) begin
      flush_d  = 1'b1;
      flush_e  = 1'b1;
      br_flush = 1'b1;
    end else if (late_stall) begin
      stall_fd = 1'b1;
      flush_e  = 1'b1;
    end
  end

  assign hz.stall_F     = stall_fd;
  assign hz.stall_D     = stall_fd;
  assign hz.stall_E     = stall_emw;
  assign hz.stall_M     = stall_emw;
  assign hz.stall_W     = stall_emw;
  assign hz.flush_D     = flush_d;
  assign hz.flush_E     = flush_e;
  assign hz.memTimeout  = mem_timeout;
  assign hz.stallCycles = stall_cnt;
  assign hz.flushCount  = flush_cnt;

  // Forward selects depend only on registered shadow state.
  fwd_select u_fwd_a (
    .rs         (rs1_e),
    .rd_M       (rd_m),
    .regWrite_M (reg_write_m),
    .rd_W       (rd_w),
    .regWrite_W (reg_write_w),
    .sel        (hz.forwardA_E)
  );

  fwd_select u_fwd_b (
    .rs         (rs2_e),
    .rd_M       (rd_m),
    .regWrite_M (reg_write_m),
    .rd_W       (rd_w),
    .regWrite_W (reg_write_w),
    .sel        (hz.forwardB_E)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      reg_write_e  <= 1'b0;
      result_src_e <= RES_ALU;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      rd_w         <= '0;
      reg_write_w  <= 1'b0;
    end else if (!freeze) begin
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      if (flush_e) begin
        rs1_e        <= '0;
        rs2_e        <= '0;
        rd_e         <= '0;
        reg_write_e  <= 1'b0;
        result_src_e <= RES_ALU;
      end else begin
        rs1_e        <= hz.rs1_D;
        rs2_e        <= hz.rs2_D;
        rd_e         <= hz.rd_D;
        reg_write_e  <= hz.regWrite_D;
        result_src_e <= hz.resultSrc_D;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (freeze) state_d = MEM_WAIT;
      MEM_WAIT: if (hz.dmemReady_M) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // The counter sits at zero in RUN, so it starts from zero on entering
  // MEM_WAIT and then counts every cycle spent there, saturating at the limit.
  assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state_q == RUN) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_inc;
      if (wait_inc == WAIT_MAX) mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_fd) stall_cnt <= stall_cnt + 1'b1;
      if (br_flush) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W = 32;
  localparam int TMO   = 4;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic [1:0] rsrc;
  } instr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int total = 0;
  int bad   = 0;

  logic [4:0] stalls;
  logic [1:0] flushes;
  assign stalls  = {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M, hz.stall_W};
  assign flushes = {hz.flush_D, hz.flush_E};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] rsrc,
                       input logic pc, input logic req, input logic rdy);
    hz.rs1_D       = rs1;
    hz.rs2_D       = rs2;
    hz.rd_D        = rd;
    hz.regWrite_D  = rw;
    hz.resultSrc_D = rsrc;
    hz.pcSrc_E     = pc;
    hz.dmemReq_M   = req;
    hz.dmemReady_M = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, RES_ALU, 0, 0, 0);
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(3, 3, 3, 1, RES_LOAD, 1, 1, 0);
    cyc();
    cyc();
    #2;
    total++; if (stalls !== 5'b00000) begin bad++; $display("FAIL reset_stalls got=%b exp=00000", stalls); end
    total++; if (flushes !== 2'b11) begin bad++; $display("FAIL reset_flushes got=%b exp=11", flushes); end
    total++; if (hz.forwardA_E !== FWD_RF) begin bad++; $display("FAIL reset_fwdA got=%b exp=00", hz.forwardA_E); end
    total++; if (hz.forwardB_E !== FWD_RF) begin bad++; $display("FAIL reset_fwdB got=%b exp=00", hz.forwardB_E); end
    total++; if (hz.stallCycles !== 32'd0) begin bad++; $display("FAIL reset_stallCycles got=%0d exp=0", hz.stallCycles); end
    total++; if (hz.flushCount !== 32'd0) begin bad++; $display("FAIL reset_flushCount got=%0d exp=0", hz.flushCount); end
    total++; if (hz.memTimeout !== 1'b0) begin bad++; $display("FAIL reset_memTimeout got=%b exp=0", hz.memTimeout); end
    reset = 1'b0;
    drive(0, 0, 0, 0, RES_ALU, 0, 0, 0);
    #1;
    total++; if (flushes !== 2'b00) begin bad++; $display("FAIL reset_release_flushes got=%b exp=00", flushes); end
    cyc();
  endtask

  task automatic test_forward();
    do_reset();
    drive(1, 2, 5, 1, RES_ALU, 0, 0, 0); cyc();
    drive(5, 1, 6, 1, RES_ALU, 0, 0, 0); #2;
    total++; if (stalls !== 5'b00000) begin bad++; $display("FAIL fwd_no_stall got=%b exp=00000", stalls); end
    cyc();
    drive(0, 0, 0, 0, RES_ALU, 0, 0, 0); #2;
    total++; if (hz.forwardA_E !== FWD_MEM) begin bad++; $display("FAIL fwd_mem_A got=%b exp=10", hz.forwardA_E); end
    total++; if (hz.forwardB_E !== FWD_RF) begin bad++; $display("FAIL fwd_mem_B got=%b exp=00", hz.forwardB_E); end
    cyc();
    drive(1, 2, 5, 1, RES_ALU, 0, 0, 0); cyc();
    drive(2, 3, 9, 1, RES_ALU, 0, 0, 0); cyc();
    drive(5, 1, 6, 1, RES_ALU, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, RES_ALU, 0, 0, 0); #2;
    total++; if (hz.forwardA_E !== FWD_WB) begin bad++; $display("FAIL fwd_wb_A got=%b exp=01", hz.forwardA_E); end
    total++; if (hz.forwardB_E !== FWD_RF) begin bad++; $display("FAIL fwd_wb_B got=%b exp=00", hz.forwardB_E); end
    cyc();
    drive(1, 2, 5, 1, RES_ALU, 0, 0, 0); cyc();
    drive(3, 4, 5, 1, RES_ALU, 0, 0, 0); cyc();
    drive(5, 5, 6, 1, RES_ALU, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, RES_ALU, 0, 0, 0); #2;
    total++; if (hz.forwardA_E !== FWD_MEM) begin bad++; $display("FAIL fwd_prio_A got=%b exp=10", hz.forwardA_E); end
    total++; if (hz.forwardB_E !== FWD_MEM) begin bad++; $display("FAIL fwd_prio_B got=%b exp=10", hz.forwardB_E); end
    cyc();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(2, 0, 7, 1, RES_LOAD, 0, 0, 0); cyc();
    drive(7, 7, 8, 1, RES_ALU, 0, 0, 0); #2;
    total++; if (stalls !== 5'b11000) begin bad++; $display("FAIL lu_stalls got=%b exp=11000", stalls); end
    total++; if (flushes !== 2'b01) begin bad++; $display("FAIL lu_flushes got=%b exp=01", flushes); end
    cyc();
    #2;
    total++; if (stalls !== 5'b00000) begin bad++; $display("FAIL lu_one_bubble got=%b exp=00000", stalls); end
    cyc();
    drive(0, 0, 0, 0, RES_ALU, 0, 0, 0); #2;
    total++; if (hz.forwardA_E !== FWD_WB) begin bad++; $display("FAIL lu_fwdA got=%b exp=01", hz.forwardA_E); end
    total++; if (hz.forwardB_E !== FWD_WB) begin bad++; $display("FAIL lu_fwdB got=%b exp=01", hz.forwardB_E); end
    total++; if (hz.stallCycles !== 32'd1) begin bad++; $display("FAIL lu_stallCycles got=%0d exp=1", hz.stallCycles); end
    cyc();
    drive(0, 0, 1, 1, RES_PC4, 0, 0, 0); cyc();
    drive(3, 1, 2, 1, RES_ALU, 0, 0, 0); #2;
    total++; if (stalls !== 5'b11000) begin bad++; $display("FAIL pc4_stalls got=%b exp=11000", stalls); end
    cyc();
    drive(0, 0, 0, 0, RES_ALU, 0, 0, 0); cyc();
  endtask

  task automatic test_x0();
    do_reset();
    drive(0, 0, 0, 1, RES_LOAD, 0, 0, 0); cyc();
    drive(0, 0, 0, 1, RES_ALU, 0, 0, 0); #2;
    total++; if (stalls !== 5'b00000) begin bad++; $display("FAIL x0_stalls got=%b exp=00000", stalls); end
    total++; if (flushes !== 2'b00) begin bad++; $display("FAIL x0_flushes got=%b exp=00", flushes); end
    cyc();
    drive(0, 0, 0, 0, RES_ALU, 0, 0, 0); #2;
    total++; if (hz.forwardA_E !== FWD_RF) begin bad++; $display("FAIL x0_fwdA got=%b exp=00", hz.forwardA_E); end
    total++; if (hz.forwardB_E !== FWD_RF) begin bad++; $display("FAIL x0_fwdB got=%b exp=00", hz.forwardB_E); end
    total++; if (hz.stallCycles !== 32'd0) begin bad++; $display("FAIL x0_stallCycles got=%0d exp=0", hz.stallCycles); end
    cyc();
  endtask

  task automatic test_branch_over_stall();
    do_reset();
    drive(2, 0, 7, 1, RES_LOAD, 0, 0, 0); cyc();
    drive(7, 0, 8, 1, RES_ALU, 1, 0, 0); #2;
    total++; if (stalls !== 5'b00000) begin bad++; $display("FAIL br_stalls got=%b exp=00000", stalls); end
    total++; if (flushes !== 2'b11) begin bad++; $display("FAIL br_flushes got=%b exp=11", flushes); end
    cyc();
    drive(0, 0, 0, 0, RES_ALU, 0, 0, 0); #2;
    total++; if (hz.flushCount !== 32'd1) begin bad++; $display("FAIL br_flushCount got=%0d exp=1", hz.flushCount); end
    total++; if (hz.stallCycles !== 32'd0) begin bad++; $display("FAIL br_stallCycles got=%0d exp=0", hz.stallCycles); end
    cyc();
  endtask

  task automatic test_mem_freeze();
    do_reset();
    drive(1, 2, 5, 1, RES_ALU, 0, 0, 0); cyc();
    drive(5, 3, 6, 1, RES_ALU, 0, 0, 0); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(6, 6, 9, 1, RES_ALU, 1, 1, 0); #2;
      total++; if (stalls !== 5'b11111) begin bad++; $display("FAIL frz_stalls_%0d got=%b exp=11111", i, stalls); end
      total++; if (flushes !== 2'b00) begin bad++; $display("FAIL frz_flushes_%0d got=%b exp=00", i, flushes); end
      total++; if (hz.forwardA_E !== FWD_MEM) begin bad++; $display("FAIL frz_hold_%0d got=%b exp=10", i, hz.forwardA_E); end
      cyc();
    end
    drive(6, 6, 9, 1, RES_ALU, 1, 1, 1); #2;
    total++; if (stalls !== 5'b00000) begin bad++; $display("FAIL frz_release_stalls got=%b exp=00000", stalls); end
    total++; if (flushes !== 2'b11) begin bad++; $display("FAIL frz_release_flushes got=%b exp=11", flushes); end
    cyc();
    drive(0, 0, 0, 0, RES_ALU, 0, 0, 0); #2;
    total++; if (hz.flushCount !== 32'd1) begin bad++; $display("FAIL frz_flushCount got=%0d exp=1", hz.flushCount); end
    total++; if (hz.stallCycles !== 32'd3) begin bad++; $display("FAIL frz_stallCycles got=%0d exp=3", hz.stallCycles); end
    total++; if (hz.memTimeout !== 1'b0) begin bad++; $display("FAIL frz_memTimeout got=%b exp=0", hz.memTimeout); end
    cyc();
  endtask

  task automatic test_timeout();
    logic exp_t;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, RES_ALU, 0, 1, 0); #2;
      // first miss cycle is still RUN; the flag shows after TMO MEM_WAIT cycles
      exp_t = (k >= TMO + 1);
      total++; if (hz.memTimeout !== exp_t) begin bad++; $display("FAIL tmo_cycle_%0d got=%b exp=%b", k, hz.memTimeout, exp_t); end
      total++; if (stalls !== 5'b11111) begin bad++; $display("FAIL tmo_freeze_%0d got=%b exp=11111", k, stalls); end
      cyc();
    end
    drive(0, 0, 0, 0, RES_ALU, 0, 1, 1); cyc();
    drive(0, 0, 0, 0, RES_ALU, 0, 0, 0); cyc();
    #2;
    total++; if (hz.memTimeout !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b exp=1", hz.memTimeout); end
    reset = 1'b1;
    #1;
    total++; if (flushes !== 2'b11) begin bad++; $display("FAIL tmo_reset_flushes got=%b exp=11", flushes); end
    cyc();
    reset = 1'b0;
    #2;
    total++; if (hz.memTimeout !== 1'b0) begin bad++; $display("FAIL tmo_reset_clear got=%b exp=0", hz.memTimeout); end
    cyc();
  endtask

  // Reference: queue of instructions that entered Execute, newest first
  // (index 0 = Execute, 1 = Memory, 2 = Writeback).
  instr_t pipe_q[$];

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    for (int i = 1; i <= 2; i++) begin
      if (pipe_q[i].rw && pipe_q[i].rd != 0 && pipe_q[i].rd == rs)
        return (i == 1) ? FWD_MEM : FWD_WB;
    end
    return FWD_RF;
  endfunction

  task automatic test_random();
    instr_t nop, d, e;
    int sc, fc, wcnt;
    bit waiting, tmo, rst, pc, req, rdy, frz, late;
    logic [4:0] exp_st;
    logic [1:0] exp_fl, exp_a, exp_b;
    nop = '0;
    do_reset();
    pipe_q = {nop, nop, nop};
    sc = 0; fc = 0; wcnt = 0; waiting = 0; tmo = 0;
    for (int n = 0; n < 1500; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      d.rs1  = 5'($urandom_range(0, 3));
      d.rs2  = 5'($urandom_range(0, 3));
      d.rd   = 5'($urandom_range(0, 3));
      d.rw   = ($urandom_range(0, 3) != 0);
      d.rsrc = 2'($urandom_range(0, 2));
      pc     = ($urandom_range(0, 9) == 0);
      req    = ($urandom_range(0, 3) == 0);
      rdy    = ($urandom_range(0, 3) == 0);
      reset  = rst;
      drive(d.rs1, d.rs2, d.rd, d.rw, d.rsrc, pc, req, rdy);
      #2;
      e    = pipe_q[0];
      frz  = req && !rdy;
      late = e.rw && e.rsrc != 0 && e.rd != 0 && (e.rd == d.rs1 || e.rd == d.rs2);
      if (rst)       begin exp_st = 5'b00000; exp_fl = 2'b11; end
      else if (frz)  begin exp_st = 5'b11111; exp_fl = 2'b00; end
      else if (pc)   begin exp_st = 5'b00000; exp_fl = 2'b11; end
      else if (late) begin exp_st = 5'b11000; exp_fl = 2'b01; end
      else           begin exp_st = 5'b00000; exp_fl = 2'b00; end
      exp_a = model_fwd(e.rs1);
      exp_b = model_fwd(e.rs2);
      total++; if (hz.forwardA_E !== exp_a) begin bad++; $display("FAIL rnd_fwdA n=%0d got=%b exp=%b", n, hz.forwardA_E, exp_a); end
      total++; if (hz.forwardB_E !== exp_b) begin bad++; $display("FAIL rnd_fwdB n=%0d got=%b exp=%b", n, hz.forwardB_E, exp_b); end
      total++; if (stalls !== exp_st) begin bad++; $display("FAIL rnd_stalls n=%0d got=%b exp=%b", n, stalls, exp_st); end
      total++; if (flushes !== exp_fl) begin bad++; $display("FAIL rnd_flushes n=%0d got=%b exp=%b", n, flushes, exp_fl); end
      total++; if (hz.stallCycles !== 32'(sc)) begin bad++; $display("FAIL rnd_stallCycles n=%0d got=%0d exp=%0d", n, hz.stallCycles, sc); end
      total++; if (hz.flushCount !== 32'(fc)) begin bad++; $display("FAIL rnd_flushCount n=%0d got=%0d exp=%0d", n, hz.flushCount, fc); end
      total++; if (hz.memTimeout !== tmo) begin bad++; $display("FAIL rnd_memTimeout n=%0d got=%b exp=%b", n, hz.memTimeout, tmo); end
      if (rst) begin
        pipe_q = {nop, nop, nop};
        sc = 0; fc = 0; wcnt = 0; waiting = 0; tmo = 0;
      end else begin
        if (exp_st[3]) sc++;
        if (!frz && pc) fc++;
        if (waiting) begin
          if (wcnt < TMO) wcnt++;
          if (wcnt >= TMO) tmo = 1;
          if (rdy) waiting = 0;
        end else if (frz) begin
          waiting = 1;
          wcnt = 0;
        end
        if (!frz) begin
          pipe_q.push_front(exp_fl[0] ? nop : d);
          void'(pipe_q.pop_back());
        end
      end
      cyc();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_x0();
    test_branch_over_stall();
    test_mem_freeze();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
